// File: rtl/riscv_pipe_ctrl_pkg.sv
// Shared constants for the pipeline control unit: forwarding selects,
// multi-cycle FSM encodings and the bubble instruction.
package riscv_pipe_ctrl_pkg;

  localparam logic [1:0] FWD_SEL_RF    = 2'd0;
  localparam logic [1:0] FWD_SEL_EXMEM = 2'd1;
  localparam logic [1:0] FWD_SEL_MEMWB = 2'd2;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Wide enough for MD_LAT-2 with MD_LAT up to 16.
  localparam int unsigned MD_CW = 4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic rd_hit(
    input logic       used,
    input logic [7:0] rs,
    input logic       wen,
    input logic [7:0] rd
  );
    return used & wen & (rd != 8'd0) & (rs == rd);
  endfunction

endpackage

// File: rtl/riscv_pipe_ctrl_md_timer.sv
// RUN/BUSY sequencer holding a multi-cycle EX op for MD_LAT cycles.
// md_stall covers the first MD_LAT-1 cycles, md_done flags the last.
module riscv_md_timer
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idex_is_md,
  output logic md_stall,
  output logic md_done
);

  localparam logic [MD_CW-1:0] CNT_INIT =
    (MD_LAT > 1) ? MD_CW'(MD_LAT - 2) : '0;
  localparam logic MULTI = (MD_LAT > 1);

  logic [0:0]       state_q, state_d;
  logic [MD_CW-1:0] md_cnt_q, md_cnt_d;

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    md_stall = 1'b0;
    md_done  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (idex_is_md && MULTI) begin
          md_stall = 1'b1;
          state_d  = ST_BUSY;
          md_cnt_d = CNT_INIT;
        end
      end
      ST_BUSY: begin
        if (md_cnt_q != '0) begin
          md_stall = 1'b1;
          md_cnt_d = md_cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
    // Reset dominates: no stall or completion is reported while held.
    if (rst) begin
      md_stall = 1'b0;
      md_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control: stalls, flushes, jump redirect, forwarding, stall count.
// Define RISCV_PIPE_CTRL_FWD_EN for forwarding; otherwise RAW hazards stall.
module riscv_pipe_ctrl
  import riscv_pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rs1_addr,
  input  logic [REG_AW-1:0] ex_rs2_addr,
  input  logic [REG_AW-1:0] idex_rd_addr,
  input  logic              idex_regs_wen,
  input  logic              idex_is_load,
  input  logic              idex_is_md,
  input  logic [REG_AW-1:0] exmem_rd_addr,
  input  logic              exmem_regs_wen,
  input  logic              exmem_is_load,
  input  logic [REG_AW-1:0] memwb_rd_addr,
  input  logic              memwb_regs_wen,
  input  logic              ex_jump_req,
  input  logic [XLEN-1:0]   ex_jump_addr,
  output logic              pc_lden,
  output logic              if_id_lden,
  output logic              id_ex_lden,
  output logic              ex_mem_lden,
  output logic              mem_wb_lden,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic              pc_jump,
  output logic [XLEN-1:0]   pc_jump_addr,
  output logic              md_busy,
  output logic              md_done,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic md_stall;
  logic hz;
  logic jump_take;
  logic hz_stall;
  logic hit_ex;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  riscv_md_timer #(
    .MD_LAT(MD_LAT)
  ) u_md_timer (
    .clk       (clk),
    .rst       (rst),
    .idex_is_md(idex_is_md),
    .md_stall  (md_stall),
    .md_done   (md_done)
  );

  assign hit_ex =
    rd_hit(id_rs1_used, 8'(id_rs1_addr),
           idex_regs_wen, 8'(idex_rd_addr)) |
    rd_hit(id_rs2_used, 8'(id_rs2_addr),
           idex_regs_wen, 8'(idex_rd_addr));

`ifdef RISCV_PIPE_CTRL_FWD_EN
  assign hz = idex_is_load & hit_ex;

  always_comb begin
    fwd_rs1_sel = FWD_SEL_RF;
    fwd_rs2_sel = FWD_SEL_RF;
    // A load in MEM has no data yet; only ALU results forward from ex_mem.
    if (exmem_regs_wen && !exmem_is_load &&
        exmem_rd_addr != '0 && exmem_rd_addr == ex_rs1_addr)
      fwd_rs1_sel = FWD_SEL_EXMEM;
    else if (memwb_regs_wen && memwb_rd_addr != '0 &&
             memwb_rd_addr == ex_rs1_addr)
      fwd_rs1_sel = FWD_SEL_MEMWB;
    if (exmem_regs_wen && !exmem_is_load &&
        exmem_rd_addr != '0 && exmem_rd_addr == ex_rs2_addr)
      fwd_rs2_sel = FWD_SEL_EXMEM;
    else if (memwb_regs_wen && memwb_rd_addr != '0 &&
             memwb_rd_addr == ex_rs2_addr)
      fwd_rs2_sel = FWD_SEL_MEMWB;
  end
`else
  logic hit_mem;
  logic hit_wb;
  logic unused_nofwd;

  assign hit_mem =
    rd_hit(id_rs1_used, 8'(id_rs1_addr),
           exmem_regs_wen, 8'(exmem_rd_addr)) |
    rd_hit(id_rs2_used, 8'(id_rs2_addr),
           exmem_regs_wen, 8'(exmem_rd_addr));
  assign hit_wb =
    rd_hit(id_rs1_used, 8'(id_rs1_addr),
           memwb_regs_wen, 8'(memwb_rd_addr)) |
    rd_hit(id_rs2_used, 8'(id_rs2_addr),
           memwb_regs_wen, 8'(memwb_rd_addr));
  assign hz = hit_ex | hit_mem | hit_wb;

  assign fwd_rs1_sel = FWD_SEL_RF;
  assign fwd_rs2_sel = FWD_SEL_RF;
  assign unused_nofwd = ^{ex_rs1_addr, ex_rs2_addr,
                          exmem_is_load, idex_is_load};
`endif

  // The jump kills the younger instruction in ID, so its hazard is moot.
  assign jump_take = !rst & ex_jump_req & !md_stall;
  assign hz_stall  = !rst & hz & !md_stall & !jump_take;

  always_comb begin
    pc_lden      = 1'b1;
    if_id_lden   = 1'b1;
    id_ex_lden   = 1'b1;
    ex_mem_lden  = 1'b1;
    mem_wb_lden  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_jump      = 1'b0;
    unique case (1'b1)
      md_stall: begin
        pc_lden      = 1'b0;
        if_id_lden   = 1'b0;
        id_ex_lden   = 1'b0;
        ex_mem_lden  = 1'b0;
        ex_mem_flush = 1'b1;
      end
      jump_take: begin
        pc_jump     = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      hz_stall: begin
        pc_lden     = 1'b0;
        if_id_lden  = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_jump_addr = ex_jump_addr;
  assign md_busy      = md_stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_lden && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule
